// File: rtl/pri_encoder_hs_pkg.sv
// Shared types and helpers for the pri_encoder_hs block.
//   state_t  : output FSM states (IDLE, PRESENT)
//   clog2_f  : ceil(log2(v)), used to size index ports
//   onehot   : 32-bit one-hot of an index, truncated by callers to N
package enc_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic [31:0] onehot(input logic [31:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/pri_encoder_hs_if.sv
// Handshake/bus bundle between event sources, the encoder and its consumer.
//   e, req      : enable and request lines into the encoder
//   out_valid   : out_idx holds a valid index
//   out_idx     : presented index (MSB priority)
//   out_ready   : consumer accepts when out_valid && out_ready
//   pend_any    : requests still waiting behind the presented one
//   ovf         : one-cycle pulse, a request hit an already pending bit
// slave = encoder side, master = source/consumer side.
interface pri_encoder_hs_if
    import enc_pkg::*;
#(
    parameter int N = 8
);
    localparam int IDX_W = clog2_f(N);

    logic             e;
    logic [N-1:0]     req;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_ready;
    logic             pend_any;
    logic             ovf;

    modport slave (
        input  e, req, out_ready,
        output out_valid, out_idx, pend_any, ovf
    );

    modport master (
        output e, req, out_ready,
        input  out_valid, out_idx, pend_any, ovf
    );
endinterface

// File: rtl/pri_enc_comb.sv
// Pure combinational N -> log2(N) priority encoder, MSB has priority.
//   req : input lines
//   idx : index of highest set bit (0 when none set)
//   any : at least one bit set
module pri_enc_comb
    import enc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]          req,
    output logic [clog2_f(N)-1:0] idx,
    output logic                  any
);
    localparam int IDX_W = clog2_f(N);

    // Ascending scan: the last hit is the highest bit.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pri_encoder_hs.sv
// Registered priority encoder with valid/ready output handshake.
// Event lines are OR-accumulated into a sticky pending register; the highest
// pending index is moved into the output register and held until accepted.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pri_encoder_hs_if.slave (e, req, out_ready in;
//                out_valid, out_idx, pend_any, ovf out)
// No starvation guarantee: a steady high-index source can block lower ones.
module pri_encoder_hs
    import enc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    pri_encoder_hs_if.slave  bus
);
    localparam int IDX_W = clog2_f(N);

    state_t           state_q;
    logic [N-1:0]     pend_q;
    logic             out_valid_q;
    logic [IDX_W-1:0] out_idx_q;
    logic             ovf_q;

    logic [IDX_W-1:0] sel;
    logic             sel_any;
    logic             load;
    logic [N-1:0]     cap;
    logic [N-1:0]     clr;
    logic [N-1:0]     pend_d;
    logic             ovf_d;

    pri_enc_comb #(.N(N)) u_sel (
        .req (pend_q),
        .idx (sel),
        .any (sel_any)
    );

    // A new index is taken whenever the output register is free or being
    // accepted this cycle; the same condition drives the FSM below.
    always_comb begin
        load   = sel_any && ((state_q == IDLE) || bus.out_ready);
        cap    = bus.e ? bus.req : '0;
        clr    = load ? N'(onehot(32'(sel))) : '0;
        // Capture after clear so a re-arriving event on the served bit is kept.
        pend_d = (pend_q & ~clr) | cap;
        ovf_d  = |(cap & pend_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            case (state_q)
                IDLE: begin
                    if (sel_any) begin
                        out_idx_q   <= sel;
                        out_valid_q <= 1'b1;
                        state_q     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.out_ready) begin
                        if (sel_any) begin
                            out_idx_q <= sel;
                        end else begin
                            out_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.pend_any  = |pend_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pri_encoder_hs.sv
// Bench for pri_encoder_hs (N=8): directed vectors with literal expectations,
// plus a behavioural event/queue model checked on every falling clock edge.
module tb_pri_encoder_hs;
    logic clk;
    logic rst_n;

    pri_encoder_hs_if #(.N(8)) bus ();

    pri_encoder_hs #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: a set of waiting events and a presented slot.
    bit   [7:0] m_pend;
    logic       m_valid;
    logic [2:0] m_idx;
    logic       m_ovf;
    int         m_hi;
    logic [7:0] m_cap;
    logic       m_take;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend  = 8'h00;
            m_valid = 1'b0;
            m_idx   = 3'd0;
            m_ovf   = 1'b0;
        end else begin
            m_cap = bus.e ? bus.req : 8'h00;
            m_hi  = -1;
            for (int i = 0; i < 8; i++) if (m_pend[i]) m_hi = i;
            m_take = (m_hi >= 0) && (!m_valid || bus.out_ready);
            m_ovf  = 1'b0;
            for (int i = 0; i < 8; i++)
                if (m_cap[i] && m_pend[i] && !(m_take && i == m_hi)) m_ovf = 1'b1;
            if (m_take) begin
                m_idx        = m_hi[2:0];
                m_pend[m_hi] = 1'b0;
                m_valid      = 1'b1;
            end else if (m_valid && bus.out_ready) begin
                m_valid = 1'b0;
            end
            m_pend = m_pend | m_cap;
        end
    end

    always @(negedge clk) begin
        check("m_valid",    32'(bus.out_valid), 32'(m_valid));
        check("m_idx",      32'(bus.out_idx),   32'(m_idx));
        check("m_pend_any", 32'(bus.pend_any),  32'(|m_pend));
        check("m_ovf",      32'(bus.ovf),       32'(m_ovf));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] vec [12];
    logic [11:0] rdy_pat;

    initial begin
        vec = '{8'h81, 8'h00, 8'h3C, 8'h00, 8'h02, 8'h02, 8'hF0, 8'h00,
                8'h11, 8'h80, 8'h00, 8'h40};
        rdy_pat = 12'b1011_0110_1101;

        rst_n         = 1'b0;
        bus.e         = 1'b1;
        bus.req       = 8'hFF;
        bus.out_ready = 1'b0;

        // Reset held with all requests asserted
        repeat (3) step();
        check("rst_valid",    32'(bus.out_valid), 32'd0);
        check("rst_idx",      32'(bus.out_idx),   32'd0);
        check("rst_ovf",      32'(bus.ovf),       32'd0);
        check("rst_pend_any", 32'(bus.pend_any),  32'd0);
        rst_n   = 1'b1;
        bus.req = 8'h00;
        step();

        // Single request
        bus.req = 8'h20; bus.out_ready = 1'b1;
        step();
        bus.req = 8'h00;
        check("single_lat", 32'(bus.out_valid), 32'd0);
        step();
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_idx",   32'(bus.out_idx),   32'd5);
        step();
        check("single_done", 32'(bus.out_valid), 32'd0);

        // Burst drains in priority order, one per cycle
        bus.req = 8'b1000_0101;
        step();
        bus.req = 8'h00;
        step();
        check("burst_idx7", 32'(bus.out_idx),  32'd7);
        check("burst_pa7",  32'(bus.pend_any), 32'd1);
        step();
        check("burst_idx2", 32'(bus.out_idx), 32'd2);
        step();
        check("burst_idx0",   32'(bus.out_idx),   32'd0);
        check("burst_valid0", 32'(bus.out_valid), 32'd1);
        check("burst_pa0",    32'(bus.pend_any),  32'd0);
        step();
        check("burst_end", 32'(bus.out_valid), 32'd0);

        // Backpressure: higher-priority arrival does not reorder the presented index
        bus.out_ready = 1'b0; bus.req = 8'h80;
        step();
        bus.req = 8'h00;
        step();
        check("bp_first", 32'(bus.out_idx), 32'd7);
        bus.req = 8'h08;
        step();
        bus.req = 8'h00;
        check("bp_hold_idx", 32'(bus.out_idx),  32'd7);
        check("bp_hold_pa",  32'(bus.pend_any), 32'd1);
        step();
        check("bp_hold2", 32'(bus.out_idx), 32'd7);
        bus.out_ready = 1'b1;
        step();
        check("bp_next",  32'(bus.out_idx),   32'd3);
        check("bp_nextv", 32'(bus.out_valid), 32'd1);
        step();
        check("bp_end", 32'(bus.out_valid), 32'd0);

        // Enable low: nothing captured
        bus.e = 1'b0; bus.req = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            step();
            check("en_off_valid", 32'(bus.out_valid), 32'd0);
        end
        bus.e = 1'b1; bus.req = 8'h00;
        step();
        check("en_off_pa", 32'(bus.pend_any), 32'd0);

        // Overflow: req[1] arrives twice while pending
        bus.out_ready = 1'b0; bus.req = 8'h80;
        step();
        bus.req = 8'h00;
        step();
        bus.req = 8'h02;
        step();
        check("ovf_first", 32'(bus.ovf), 32'd0);
        bus.req = 8'h00;
        step();
        check("ovf_quiet", 32'(bus.ovf), 32'd0);
        bus.req = 8'h02;
        step();
        check("ovf_pulse", 32'(bus.ovf), 32'd1);
        bus.req = 8'h00;
        step();
        check("ovf_clear", 32'(bus.ovf), 32'd0);
        bus.out_ready = 1'b1;
        step();
        check("ovf_drain", 32'(bus.out_idx), 32'd1);
        step();
        check("ovf_end", 32'(bus.out_valid), 32'd0);

        // Mid-transfer async reset
        bus.out_ready = 1'b0; bus.req = 8'h80;
        step();
        bus.req = 8'h0C;
        step();
        bus.req = 8'h00;
        step();
        check("mid_pre_idx", 32'(bus.out_idx),  32'd7);
        check("mid_pre_pa",  32'(bus.pend_any), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_pa",    32'(bus.pend_any),  32'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_after", 32'(bus.out_valid), 32'd0);
        end

        // Mixed vectors with varying ready, checked against the model
        for (int i = 0; i < 12; i++) begin
            bus.req       = vec[i];
            bus.e         = (i != 6);
            bus.out_ready = rdy_pat[i];
            step();
        end
        bus.req = 8'h00; bus.e = 1'b1; bus.out_ready = 1'b1;
        repeat (10) step();
        check("final_drain", 32'(bus.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
